// File: rtl/jit_template_emitter_if.sv
// Request and word-stream handshake bundle between the JIT front end,
// the template emitter and the code-cache writer.
interface jit_template_emitter_if #(
    parameter int CNT_W   = 4,
    parameter int CODE_AW = 10
);
    logic               req_valid;
    logic               req_ready;
    logic [6:0]         req_idx;
    logic [CNT_W-1:0]   req_count;
    logic               req_patch_en;
    logic [CNT_W-1:0]   req_patch_pos;
    logic [23:0]        req_patch_imm;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_word;
    logic [CODE_AW-1:0] out_addr;
    logic               out_last;

    // The emitter sits on the slave side: it takes requests and sources words.
    modport slave (
        input  req_valid, req_idx, req_count, req_patch_en, req_patch_pos, req_patch_imm,
        input  out_ready,
        output req_ready, out_valid, out_word, out_addr, out_last
    );

    modport master (
        output req_valid, req_idx, req_count, req_patch_en, req_patch_pos, req_patch_imm,
        output out_ready,
        input  req_ready, out_valid, out_word, out_addr, out_last
    );
endinterface

// File: rtl/jit_template_emitter.sv
// Walks the instruction-template ROM for one bytecode request, optionally
// patches one word's imm24 field, and streams tagged words to the code cache.
//
// state | meaning
// IDLE  | ready for a request; code pointer may be loaded
// FETCH | read ROM at idx, register the (patched) word
// EMIT  | hold the word on out_* until accepted
// DONE  | one-cycle done pulse, back to IDLE
module jit_template_emitter #(
    parameter int ROM_DEPTH = 67,
    parameter int CODE_AW   = 10,
    parameter int CNT_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cp_load,
    input  logic [CODE_AW-1:0]  cp_value,
    jit_template_emitter_if.slave bus,
    output logic [6:0]          rom_addr,
    input  logic [31:0]         rom_data,
    output logic                done,
    output logic                err,
    output logic [CODE_AW-1:0]  code_ptr
);
    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    localparam logic [7:0] DEPTH8 = 8'(ROM_DEPTH);

    state_t             state_q, state_d;
    logic [6:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   pos_q, pos_d;
    logic               patch_en_q, patch_en_d;
    logic [CNT_W-1:0]   patch_pos_q, patch_pos_d;
    logic [23:0]        patch_imm_q, patch_imm_d;
    logic [CODE_AW-1:0] code_ptr_q, code_ptr_d;
    logic [31:0]        out_word_q, out_word_d;
    logic [CODE_AW-1:0] out_addr_q, out_addr_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [7:0]         req_end;
    logic               req_reject;

    // Range check is 8 bits wide so idx near the top of the ROM cannot wrap.
    assign req_end    = {1'b0, bus.req_idx} + 8'(bus.req_count);
    assign req_reject = (bus.req_count == '0) || (req_end > DEPTH8) ||
                        (bus.req_patch_en && (bus.req_patch_pos >= bus.req_count));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        pos_d       = pos_q;
        patch_en_d  = patch_en_q;
        patch_pos_d = patch_pos_q;
        patch_imm_d = patch_imm_q;
        code_ptr_d  = code_ptr_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cp_load) begin
                    code_ptr_d = cp_value;
                end
                if (bus.req_valid) begin
                    if (req_reject) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d       = bus.req_idx;
                        remaining_d = bus.req_count;
                        pos_d       = '0;
                        patch_en_d  = bus.req_patch_en;
                        patch_pos_d = bus.req_patch_pos;
                        patch_imm_d = bus.req_patch_imm;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                out_word_d  = (patch_en_q && (pos_q == patch_pos_q)) ?
                              {rom_data[31:24], patch_imm_q} : rom_data;
                out_addr_d  = code_ptr_q;
                out_last_d  = (remaining_q == CNT_W'(1));
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = idx_q + 7'd1;
                    pos_d       = pos_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    code_ptr_d  = code_ptr_q + CODE_AW'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            remaining_q <= '0;
            pos_q       <= '0;
            patch_en_q  <= 1'b0;
            patch_pos_q <= '0;
            patch_imm_q <= '0;
            code_ptr_q  <= '0;
            out_word_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            pos_q       <= pos_d;
            patch_en_q  <= patch_en_d;
            patch_pos_q <= patch_pos_d;
            patch_imm_q <= patch_imm_d;
            code_ptr_q  <= code_ptr_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // rom_addr follows the latched index, so it reads 0 straight out of reset.
    assign rom_addr      = idx_q;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
    assign done          = done_q;
    assign err           = err_q;
    assign code_ptr      = code_ptr_q;
endmodule

// File: tb/tb_jit_template_emitter.sv
// Randomised and directed bench for jit_template_emitter against a
// request-level model (expected word list per request, code pointer counter).
module tb_jit_template_emitter;
    localparam int ROM_DEPTH = 67;
    localparam int CODE_AW   = 10;
    localparam int CNT_W     = 4;

    typedef struct {
        logic [CODE_AW-1:0] addr;
        logic [31:0]        word;
        logic               last;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               cp_load;
    logic [CODE_AW-1:0] cp_value;
    logic [6:0]         rom_addr;
    logic [31:0]        rom_data;
    logic               done;
    logic               err;
    logic [CODE_AW-1:0] code_ptr;

    logic [31:0] rom [0:127];
    exp_t        exp_q[$];
    exp_t        seen[$];
    int          checks   = 0;
    int          failures = 0;
    int          ready_mode = 0;
    int          model_cp = 0;

    jit_template_emitter_if #(.CNT_W(CNT_W), .CODE_AW(CODE_AW)) bus ();

    jit_template_emitter #(.ROM_DEPTH(ROM_DEPTH), .CODE_AW(CODE_AW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cp_load  (cp_load),
        .cp_value (cp_value),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .done     (done),
        .err      (err),
        .code_ptr (code_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Compare process: whenever a word is offered it must match the head of the model list.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%h required=none", bus.out_word);
            end else begin
                chk("out_word", bus.out_word, exp_q[0].word);
                chk("out_addr", 32'(bus.out_addr), 32'(exp_q[0].addr));
                chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
                if (bus.out_ready) begin
                    seen.push_back('{addr: bus.out_addr, word: bus.out_word, last: bus.out_last});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic issue(input logic [6:0] idx, input logic [3:0] cnt, input logic pe,
                         input logic [3:0] pp, input logic [23:0] pi,
                         input logic cpl, input logic [CODE_AW-1:0] cpv, output bit acc);
        bit    reject;
        logic [31:0] w;
        @(posedge clk); #1;
        bus.req_idx       = idx;
        bus.req_count     = cnt;
        bus.req_patch_en  = pe;
        bus.req_patch_pos = pp;
        bus.req_patch_imm = pi;
        bus.req_valid     = 1'b1;
        cp_load           = cpl;
        cp_value          = cpv;
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid     = 1'b0;
        bus.req_idx       = 7'($urandom);
        bus.req_count     = 4'($urandom);
        bus.req_patch_en  = 1'($urandom);
        bus.req_patch_pos = 4'($urandom);
        bus.req_patch_imm = 24'($urandom);
        cp_load           = 1'b0;
        if (cpl) model_cp = int'(cpv);
        reject = (cnt == 0) || (int'(idx) + int'(cnt) > ROM_DEPTH) || (pe && pp >= cnt);
        if (!reject) begin
            for (int i = 0; i < int'(cnt); i++) begin
                w = rom[int'(idx) + i];
                if (pe && i == int'(pp)) w = {w[31:24], pi};
                exp_q.push_back('{addr: CODE_AW'((model_cp + i) % 1024), word: w,
                                  last: (i == int'(cnt) - 1)});
            end
            model_cp = (model_cp + int'(cnt)) % 1024;
            // Busy-time pointer loads must be ignored.
            cp_load  = 1'($urandom);
            cp_value = CODE_AW'($urandom);
        end
        @(negedge clk);
        chk("err_after_req", 32'(err), 32'(reject));
        chk("no_valid_1cyc", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        if (reject) begin
            chk("err_pulse_end", 32'(err), 32'd0);
            chk("cp_after_rej", 32'(code_ptr), 32'(model_cp));
            chk("no_valid_rej", 32'(bus.out_valid), 32'd0);
        end else begin
            chk("first_valid_lat", 32'(bus.out_valid), 32'd1);
        end
        acc = !reject;
    endtask

    task automatic wait_done(input int hold);
        bit got = 0;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            ready_mode = 0;
        end
        for (int c = 0; c < 3000 && !got; c++) begin
            if (done) got = 1;
            else @(negedge clk);
        end
        cp_load = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("code_ptr", 32'(code_ptr), 32'(model_cp));
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("ready_after_done", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run_req(input logic [6:0] idx, input logic [3:0] cnt, input logic pe,
                           input logic [3:0] pp, input logic [23:0] pi,
                           input logic cpl, input logic [CODE_AW-1:0] cpv, input int hold);
        bit acc;
        issue(idx, cnt, pe, pp, pi, cpl, cpv, acc);
        if (acc) wait_done(hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = (i < ROM_DEPTH) ? (32'hE3A00000 ^ (32'(i) * 32'h00010203)) : 32'h0;
        rom[1]  = 32'hE49D0004;
        rom[2]  = 32'hE52D0004;
        rom[7]  = 32'hE1A02000;
        rom[16] = 32'hED2D0B02;
        rom[17] = 32'hEEB70B00;
        rom[43] = 32'hE92D4800;
        rom[44] = 32'hEBFFFFFE;
        rom[45] = 32'hE8BD4800;

        rst_n = 1'b0; cp_load = 1'b0; cp_value = '0;
        bus.req_valid = 1'b0; bus.req_idx = '0; bus.req_count = '0;
        bus.req_patch_en = 1'b0; bus.req_patch_pos = '0; bus.req_patch_imm = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_word", bus.out_word, 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_code_ptr", 32'(code_ptr), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;

        // Basic two-word emit.
        seen.delete();
        run_req(7'h01, 4'd2, 1'b0, 4'd0, 24'h0, 1'b0, '0, 0);
        chk("basic_n", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("basic_w0", seen[0].word, 32'hE49D0004);
            chk("basic_a0", 32'(seen[0].addr), 32'h000);
            chk("basic_w1", seen[1].word, 32'hE52D0004);
            chk("basic_l1", 32'(seen[1].last), 32'd1);
        end
        chk("basic_cp", 32'(code_ptr), 32'h002);

        // Patched BL offset.
        seen.delete();
        run_req(7'h2B, 4'd3, 1'b1, 4'd1, 24'h000010, 1'b0, '0, 0);
        chk("patch_n", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("patch_w0", seen[0].word, 32'hE92D4800);
            chk("patch_w1", seen[1].word, 32'hEB000010);
            chk("patch_w2", seen[2].word, 32'hE8BD4800);
        end

        // Backpressure: word held for 5 cycles then one accept.
        seen.delete();
        ready_mode = 2;
        run_req(7'h07, 4'd1, 1'b0, 4'd0, 24'h0, 1'b0, '0, 5);
        chk("bp_n", 32'(seen.size()), 32'd1);
        if (seen.size() == 1) chk("bp_w", seen[0].word, 32'hE1A02000);

        // Rejects leave code_ptr alone.
        run_req(7'h41, 4'd3, 1'b0, 4'd0, 24'h0, 1'b0, '0, 0);
        run_req(7'h05, 4'd0, 1'b0, 4'd0, 24'h0, 1'b0, '0, 0);
        run_req(7'h05, 4'd2, 1'b1, 4'd2, 24'h0, 1'b0, '0, 0);
        chk("rej_cp", 32'(code_ptr), 32'h006);

        // Same-cycle pointer load and address wrap.
        seen.delete();
        run_req(7'h10, 4'd2, 1'b0, 4'd0, 24'h0, 1'b1, 10'h3FF, 0);
        if (seen.size() == 2) begin
            chk("wrap_a0", 32'(seen[0].addr), 32'h3FF);
            chk("wrap_a1", 32'(seen[1].addr), 32'h000);
            chk("wrap_w1", seen[1].word, 32'hEEB70B00);
        end else chk("wrap_n", 32'(seen.size()), 32'd2);
        chk("wrap_cp", 32'(code_ptr), 32'h001);

        // Randomised requests, including rejects and random backpressure.
        ready_mode = 1;
        for (int n = 0; n < 80; n++) begin
            run_req(7'($urandom_range(0, 70)), 4'($urandom), ($urandom_range(0, 2) == 0),
                    4'($urandom), 24'($urandom), ($urandom_range(0, 3) == 0),
                    CODE_AW'($urandom), 0);
        end
        ready_mode = 0;

        // Reset in the middle of a four-word request.
        begin
            bit acc;
            issue(7'h20, 4'd4, 1'b0, 4'd0, 24'h0, 1'b0, '0, acc);
            rst_n = 1'b0;
            cp_load = 1'b0;
            #1;
            chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
            chk("mid_rst_word", bus.out_word, 32'd0);
            chk("mid_rst_addr", 32'(bus.out_addr), 32'd0);
            chk("mid_rst_cp", 32'(code_ptr), 32'd0);
            chk("mid_rst_flags", {29'd0, done, err, bus.out_last}, 32'd0);
            exp_q.delete();
            seen.delete();
            model_cp = 0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
            run_req(7'h01, 4'd2, 1'b0, 4'd0, 24'h0, 1'b0, '0, 0);
            if (seen.size() == 2) begin
                chk("post_rst_a0", 32'(seen[0].addr), 32'h000);
                chk("post_rst_w1", seen[1].word, 32'hE52D0004);
            end else chk("post_rst_n", 32'(seen.size()), 32'd2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jit_template_emitter.md
Name: jit_template_emitter

Overview:
- Sequences the ARM instruction-template ROM (`com_rom`: 7-bit index in, 32-bit word out, combinational) for the JVM-to-ARM JIT.
- Accepts one translation request per bytecode. Each request gives a start index, a word count, and an optional 24-bit immediate patch.
- Walks the ROM entries in order and optionally patches one word's imm24 field, e.g. the BL offset in template EBFFFFFE.
- Streams the resulting words, each tagged with a code-buffer address, to the code-cache writer over a valid/ready handshake.

Parameters:
- ROM_DEPTH, 67, number of valid ROM entries (indices 0..ROM_DEPTH-1).
- CODE_AW, 10, width of the code-buffer word address; wraps modulo 2^CODE_AW.
- CNT_W, 4, width of the request word count (max 15 words).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cp_load, input, 1, load the code pointer (honoured in IDLE only).
- cp_value, input, CODE_AW, new code pointer value.
- req_valid, input, 1, request present.
- req_ready, output, 1, emitter can accept a request.
- req_idx, input, 7, first ROM index.
- req_count, input, CNT_W, number of words to emit.
- req_patch_en, input, 1, patch one word of the sequence.
- req_patch_pos, input, CNT_W, 0-based position of the word to patch.
- req_patch_imm, input, 24, value replacing bits [23:0] of the patched word.
- rom_addr, output, 7, index driven to com_rom.
- rom_data, input, 32, com_rom output (same cycle).
- out_valid, output, 1, out_word/out_addr valid.
- out_ready, input, 1, downstream accepts the word.
- out_word, output, 32, emitted instruction.
- out_addr, output, CODE_AW, code-buffer address for out_word.
- out_last, output, 1, final word of the current request.
- done, output, 1, one-cycle pulse after the last word is accepted.
- err, output, 1, one-cycle pulse on a rejected request.
- code_ptr, output, CODE_AW, current next-free code-buffer address.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - code_ptr=0, rom_addr=0, out_word=0, out_addr=0.
  - out_valid, out_last, done and err are 0.
  - Reset mid-request abandons the request silently; no done pulse.
- States: IDLE, FETCH, EMIT, DONE.
- req_ready = (state==IDLE).
- IDLE:
  - cp_load=1 loads code_ptr<=cp_value.
  - If cp_load and req_valid occur in the same cycle, the load applies first and the request uses the new pointer.
  - Request handshake: req_valid & req_ready.
  - The request is rejected if req_count==0, or req_idx+req_count>ROM_DEPTH (computed 8 bits wide), or (req_patch_en and req_patch_pos>=req_count).
  - On reject: err=1 for the next cycle, stay IDLE, nothing emitted.
  - On accept: latch idx, remaining=req_count, pos=0, and the patch fields; go to FETCH.
- FETCH (1 cycle):
  - rom_addr=idx.
  - Register out_word <= (patch_en && pos==patch_pos) ? {rom_data[31:24], patch_imm} : rom_data.
  - out_addr<=code_ptr, out_last<=(remaining==1), out_valid<=1; go to EMIT.
- EMIT:
  - Hold out_valid, out_word, out_addr and out_last stable until out_ready=1.
  - On handshake: out_valid<=0, idx++, pos++, remaining--, code_ptr<=code_ptr+1 (wraps 2^CODE_AW-1 -> 0).
  - Then go to DONE if remaining was 1, else FETCH.
- DONE: done=1 for one cycle, go to IDLE.
- Latency and throughput:
  - Request accept to first out_valid: 2 cycles.
  - Sustained throughput: 1 word per 2 cycles with out_ready held high.
  - Request to request: count*2+2 cycles minimum.
- cp_load outside IDLE is ignored.
- Input changes after acceptance have no effect.

Test Plan:
- Basic emit, code_ptr=0x000: req_idx=0x01, count=2 -> (0x000, E49D0004), (0x001, E52D0004 with out_last=1); done pulse; code_ptr=0x002.
- Patch: req_idx=0x2B, count=3, patch_en, pos=1, imm=0x000010 -> E92D4800, EB000010, E8BD4800.
- Backpressure: out_ready low for 5 cycles during word 0 of idx=0x07, count=1 -> out_word E1A02000 and out_addr held stable; a single accept; done follows.
- Rejects:
  - idx=0x41, count=3 -> err pulse, no out_valid.
  - count=0 -> err.
  - patch_pos=2 with count=2 -> err.
  - code_ptr unchanged in all three cases.
- Wrap: cp_load 0x3FF, idx=0x10, count=2 -> addresses 0x3FF then 0x000 (ED2D0B02, EEB70B00); code_ptr=0x001.
- Reset mid-request: assert rst_n=0 during EMIT of a count=4 request -> all outputs 0 asynchronously, no done pulse; after release req_ready=1 and a new request works from code_ptr=0.
